// File: rtl/imem_axi_pkg.sv
// Shared types and constants for the instruction-fetch AXI read-address queue.
// The 4 KiB helper is only used when IMEM_AR_4K_CHECK_EN is defined.
package imem_axi_pkg;

    localparam int AR_ADDR_MAX_W   = 64;
    localparam int AXI_4K_BOUNDARY = 4096;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef struct packed {
        logic [AR_ADDR_MAX_W-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } ar_req_t;

    // Address of the last byte of the burst, within the page, computed in 13 bits;
    // anything at or beyond one page means the burst spills into the next page.
    function automatic logic crosses_4k(input logic [11:0] offs,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [12:0] last_byte;
        last_byte = {1'b0, offs} + ((13'(len) + 13'd1) << size) - 13'd1;
        return last_byte >= 13'(AXI_4K_BOUNDARY);
    endfunction

endpackage

// File: rtl/imem_ar_fifo.sv
// Synchronous FIFO of AR requests with wrap-bit pointers; head is the entry at
// the read pointer, so the payload only changes when an entry is popped.
module imem_ar_fifo
    import imem_axi_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          axi_clk,
    input  logic          axi_resetn,
    input  logic          push,
    input  logic          pop,
    input  ar_req_t       wdata,
    output ar_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] level
);

    ar_req_t       mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign head    = mem[rptr[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wptr <= '0;
            rptr <= '0;
            // NOTE: storage is reset deliberately so the AR outputs read 0 out of
            // reset; this costs a reset net per entry but DEPTH is small.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/imem_axi_ar_queue.sv
// Fetch-side AR request queue: buffers requests, issues them in order with an
// incrementing ARID, and caps outstanding bursts. Optional: IMEM_AR_4K_CHECK_EN.
module imem_axi_ar_queue
    import imem_axi_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter int ID_W      = 4
) (
    input  logic                   axi_clk,
    input  logic                   axi_resetn,
    input  logic [ADDR_W-1:0]      araddr_i,
    input  logic [7:0]             arlen_i,
    input  logic [2:0]             arsize_i,
    input  logic [1:0]             arburst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   arready_i,
    output logic [ADDR_W-1:0]      araddr_o,
    output logic [7:0]             arlen_o,
    output logic [2:0]             arsize_o,
    output logic [1:0]             arburst_o,
    output logic [ID_W-1:0]        arid_o,
    output logic                   arvalid_o,
    input  logic                   rvalid_i,
    input  logic                   rready_i,
    input  logic                   rlast_i,
    output logic [7:0]             outst_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   req_err_o
);

    ar_req_t         in_req;
    ar_req_t         head;
    logic            full;
    logic            empty;
    logic            push;
    logic            fifo_push;
    logic            pop;
    logic            retire;
    logic [7:0]      outst_q;
    logic [ID_W-1:0] id_q;

    assign in_req.addr  = AR_ADDR_MAX_W'(araddr_i);
    assign in_req.len   = arlen_i;
    assign in_req.size  = arsize_i;
    assign in_req.burst = arburst_i;

    assign ready_o = ~full;
    assign push    = valid_i & ~full;
    assign retire  = rvalid_i & rready_i & rlast_i;

    // The gate only opens through registered state, so once arvalid_o rises it
    // cannot fall before the handshake: outst_q only grows on a handshake.
    assign arvalid_o = ~empty & (outst_q < 8'(MAX_OUTST));
    assign pop       = arvalid_o & arready_i;

    assign araddr_o  = head.addr[ADDR_W-1:0];
    assign arlen_o   = head.len;
    assign arsize_o  = head.size;
    assign arburst_o = head.burst;
    assign arid_o    = id_q;
    assign outst_o   = outst_q;

    imem_ar_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .push       (fifo_push),
        .pop        (pop),
        .wdata      (in_req),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .level      (level_o)
    );

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            outst_q <= '0;
            id_q    <= '0;
        end else begin
            if (pop) begin
                id_q <= id_q + ID_W'(1);
            end
            case ({pop, retire})
                2'b10:   outst_q <= outst_q + 8'd1;
                2'b01:   if (outst_q != '0) outst_q <= outst_q - 8'd1;
                default: ;
            endcase
        end
    end

    retire_without_outstanding: assert property (
        @(posedge axi_clk) disable iff (!axi_resetn) !(retire && outst_q == '0)
    );

`ifdef IMEM_AR_4K_CHECK_EN
    logic cross_4k;
    logic req_err_q;

    // A crossing request is still handshaken so the fetch side never stalls on it.
    assign cross_4k  = (arburst_i == BURST_INCR) &&
                       crosses_4k(araddr_i[11:0], arlen_i, arsize_i);
    assign fifo_push = push & ~cross_4k;
    assign req_err_o = req_err_q;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            req_err_q <= 1'b0;
        end else begin
            req_err_q <= push & cross_4k;
        end
    end
`else
    assign fifo_push = push;
    assign req_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_axi_ar_queue.sv
// Scoreboard bench: stimulus queues expected AR bursts, a monitor checks each
// AR handshake; status outputs are checked directly. Covers IMEM_AR_4K_CHECK_EN.
module tb_imem_axi_ar_queue;
    import imem_axi_pkg::*;

    logic        axi_clk = 1'b0;
    logic        axi_resetn;
    logic [63:0] araddr_i;
    logic [7:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        valid_i;
    logic        ready_o;
    logic        arready_i;
    logic [63:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [1:0]  arid_o;
    logic        arvalid_o;
    logic        rvalid_i;
    logic        rready_i;
    logic        rlast_i;
    logic [7:0]  outst_o;
    logic [2:0]  level_o;
    logic        req_err_o;

    int checks = 0;
    int errors = 0;
    ar_req_t   exp_q[$];
    logic [1:0] exp_id = '0;

    imem_axi_ar_queue #(
        .ADDR_W    (64),
        .DEPTH     (4),
        .MAX_OUTST (2),
        .ID_W      (2)
    ) dut (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .araddr_i   (araddr_i),
        .arlen_i    (arlen_i),
        .arsize_i   (arsize_i),
        .arburst_i  (arburst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .arready_i  (arready_i),
        .araddr_o   (araddr_o),
        .arlen_o    (arlen_o),
        .arsize_o   (arsize_o),
        .arburst_o  (arburst_o),
        .arid_o     (arid_o),
        .arvalid_o  (arvalid_o),
        .rvalid_i   (rvalid_i),
        .rready_i   (rready_i),
        .rlast_i    (rlast_i),
        .outst_o    (outst_o),
        .level_o    (level_o),
        .req_err_o  (req_err_o)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic push_req(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit exp_accept, input bit exp_enq);
        araddr_i  = addr;
        arlen_i   = len;
        arsize_i  = size;
        arburst_i = burst;
        valid_i   = 1'b1;
        check("ready_at_push", ready_o, exp_accept);
        if (exp_accept && exp_enq) exp_q.push_back('{addr, len, size, burst});
        tick();
        valid_i = 1'b0;
    endtask

    task automatic set_retire(input logic v);
        rvalid_i = v;
        rready_i = v;
        rlast_i  = v;
    endtask

    task automatic drain();
        int n = 0;
        arready_i = 1'b1;
        while ((level_o != 0 || outst_o != 0) && n < 50) begin
            set_retire(outst_o != 0);
            tick();
            n++;
        end
        arready_i = 1'b0;
        set_retire(1'b0);
        check("drain_level", level_o, 0);
        check("drain_outst", outst_o, 0);
    endtask

    // Monitor: every AR handshake must match the oldest queued request, in order,
    // with ARID counting up from 0 after each reset.
    always @(negedge axi_clk) begin
        if (!axi_resetn) begin
            exp_id = '0;
        end else if (arvalid_o && arready_i) begin
            if (exp_q.size() == 0) begin
                check("ar_unexpected", araddr_o, 64'hDEAD_BEEF);
            end else begin
                ar_req_t e;
                e = exp_q.pop_front();
                check("ar_addr", araddr_o, e.addr);
                check("ar_len", arlen_o, e.len);
                check("ar_size", arsize_o, e.size);
                check("ar_burst", arburst_o, e.burst);
                check("ar_id", arid_o, exp_id);
                exp_id = exp_id + 2'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        axi_resetn = 1'b0;
        araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0;
        valid_i = 1'b0; arready_i = 1'b0;
        set_retire(1'b0);
        #2;
        check("rst_arvalid", arvalid_o, 0);
        check("rst_ready", ready_o, 1);
        #12 axi_resetn = 1'b1;
        tick();
        check("init_ready", ready_o, 1);
        check("init_arvalid", arvalid_o, 0);
        check("init_araddr", araddr_o, 0);
        check("init_arid", arid_o, 0);
        check("init_level", level_o, 0);
        check("init_outst", outst_o, 0);
        check("init_req_err", req_err_o, 0);

        // Single request, no bypass, then AR handshake and retire.
        push_req(64'h1000, 8'd7, 3'd3, 2'b01, 1, 1);
        check("single_arvalid", arvalid_o, 1);
        check("single_arid", arid_o, 0);
        check("single_araddr", araddr_o, 64'h1000);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("single_arvalid_drop", arvalid_o, 0);
        check("single_outst", outst_o, 1);
        set_retire(1'b1);
        tick();
        set_retire(1'b0);
        check("single_retired", outst_o, 0);

        // Fill to DEPTH; the fifth request must be refused.
        push_req(64'h2000, 8'd3, 3'd2, 2'b01, 1, 1);
        push_req(64'h2040, 8'd1, 3'd3, 2'b00, 1, 1);
        push_req(64'h2080, 8'd15, 3'd2, 2'b10, 1, 1);
        push_req(64'h20C0, 8'd0, 3'd1, 2'b01, 1, 1);
        check("full_ready", ready_o, 0);
        check("full_level", level_o, 4);
        push_req(64'h3000, 8'd0, 3'd0, 2'b01, 0, 0);
        check("full_level_hold", level_o, 4);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("freed_ready", ready_o, 1);
        check("freed_level", level_o, 3);
        check("freed_outst", outst_o, 1);

        // Handshake and R-last together at outst=1.
        arready_i = 1'b1;
        set_retire(1'b1);
        tick();
        set_retire(1'b0);
        check("same_cycle_outst", outst_o, 1);
        check("same_cycle_level", level_o, 2);

        // Outstanding limit with ARREADY held high.
        tick();
        check("limit_outst", outst_o, 2);
        check("limit_arvalid", arvalid_o, 0);
        tick();
        check("limit_hold_arvalid", arvalid_o, 0);
        check("limit_hold_level", level_o, 1);
        set_retire(1'b1);
        tick();
        set_retire(1'b0);
        check("limit_reopen_arvalid", arvalid_o, 1);
        check("id_wrap_arid", arid_o, 0);
        tick();
        arready_i = 1'b0;
        check("limit_outst_again", outst_o, 2);
        check("limit_level_empty", level_o, 0);
        drain();

        // Asynchronous reset with bursts queued and outstanding.
        push_req(64'h4000, 8'd7, 3'd3, 2'b01, 1, 1);
        push_req(64'h4100, 8'd7, 3'd3, 2'b01, 1, 0);
        push_req(64'h4200, 8'd7, 3'd3, 2'b01, 1, 0);
        push_req(64'h4300, 8'd7, 3'd3, 2'b01, 1, 0);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("prerst_level", level_o, 3);
        check("prerst_arvalid", arvalid_o, 1);
        check("prerst_outst", outst_o, 1);
        #2;
        axi_resetn = 1'b0;
        exp_q.delete();
        #1;
        check("async_arvalid", arvalid_o, 0);
        check("async_araddr", araddr_o, 0);
        check("async_arlen", arlen_o, 0);
        check("async_arsize", arsize_o, 0);
        check("async_arburst", arburst_o, 0);
        check("async_arid", arid_o, 0);
        check("async_level", level_o, 0);
        check("async_outst", outst_o, 0);
        #3 axi_resetn = 1'b1;
        tick();
        check("postrst_ready", ready_o, 1);
        check("postrst_arvalid", arvalid_o, 0);

        // 4 KiB boundary: last byte 0xFFF fits, 0x1007 crosses, WRAP is never checked.
        push_req(64'h0FC0, 8'd7, 3'd3, 2'b01, 1, 1);
        check("edge_fit_err", req_err_o, 0);
        check("edge_fit_level", level_o, 1);
        check("postrst_arid", arid_o, 0);
`ifdef IMEM_AR_4K_CHECK_EN
        push_req(64'h0FC8, 8'd7, 3'd3, 2'b01, 1, 0);
        check("cross_err_pulse", req_err_o, 1);
        check("cross_level", level_o, 1);
`else
        push_req(64'h0FC8, 8'd7, 3'd3, 2'b01, 1, 1);
        check("cross_err_off", req_err_o, 0);
        check("cross_level", level_o, 2);
`endif
        push_req(64'h0FC8, 8'd7, 3'd3, 2'b10, 1, 1);
        check("wrap_err", req_err_o, 0);
        drain();

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_axi_ar_queue.md
Name: imem_axi_ar_queue

Overview:
- Parametrised successor to the single-entry instruction-fetch AR request bridge; sits in the AXI clock domain between the fetch-side request path and the AXI read-address channel.
- Buffers up to DEPTH read-address requests in a FIFO and issues them in order on AR.
- Limits the number of outstanding bursts, using R-channel last beats to retire them.
- Tags each issued burst with an incrementing ARID.

Parameters:
- ADDR_W, 64, address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUTST, 2, maximum AR bursts issued but not yet retired by an R-last handshake; range 1..255.
- ID_W, 4, ARID width.

Ports:
- axi_clk  in  1  clock; the block's only clock.
- axi_resetn  in  1  reset; asynchronous, active-low.
- araddr_i  in  ADDR_W  request address.
- arlen_i  in  8  request burst length minus 1.
- arsize_i  in  3  request beat size, log2 bytes.
- arburst_i  in  2  request burst type.
- valid_i  in  1  request valid.
- ready_o  out  1  request ready; high when the FIFO is not full.
- arready_i  in  1  AXI ARREADY.
- araddr_o  out  ADDR_W  AXI ARADDR.
- arlen_o  out  8  AXI ARLEN.
- arsize_o  out  3  AXI ARSIZE.
- arburst_o  out  2  AXI ARBURST.
- arid_o  out  ID_W  AXI ARID.
- arvalid_o  out  1  AXI ARVALID.
- rvalid_i  in  1  observed RVALID.
- rready_i  in  1  observed RREADY.
- rlast_i  in  1  observed RLAST.
- outst_o  out  8  current outstanding-burst count.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- req_err_o  out  1  rejected-request pulse; used only with the optional feature.

Behaviour:
- Reset: on negedge axi_resetn, immediately clear the following state:
  - FIFO pointers
  - all storage entries
  - outstanding counter
  - ID counter
  - req_err_o
- Values out of reset:
  - All AR outputs are 0 and arvalid_o is 0.
  - ready_o is 1 after reset, because the FIFO is empty.
  - Reset mid-burst discards all queued and outstanding state; no recovery is attempted.
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty = (wptr == rptr).
  - full = MSBs differ and the remaining bits are equal.
  - level_o = wptr - rptr, modulo the pointer width.
- Enqueue: push = valid_i & ready_o, with ready_o = ~full. On a push, the entry {addr, len, size, burst} is written at wptr and wptr increments.
  - No bypass: a request accepted in cycle N appears on AR no earlier than cycle N+1.
- Issue: arvalid_o = ~empty & (outst_q < MAX_OUTST).
  - AR outputs are driven from the entry at rptr; arid_o = id_q.
  - AR handshake (arvalid_o & arready_i): rptr increments, id_q increments and wraps modulo 2^ID_W, and outst_q increments.
  - Once arvalid_o rises it holds with stable payload until the handshake. outst_q can only rise through a handshake, and the head entry changes only on a pop, so this holds by construction.
- Retire: rvalid_i & rready_i & rlast_i decrements outst_q.
  - Handshake and retire in the same cycle: outst_q is unchanged.
  - Retire with outst_q == 0 is a protocol error; outst_q saturates at 0 and a simulation assertion fires.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect and level_o is unchanged.
  - When full, a pop frees a slot only in the next cycle, because ready_o is computed from the registered state.
- outst_o = outst_q.

Optional Feature:
- Macro IMEM_AR_4K_CHECK_EN.
- Defined: at enqueue, compute end = araddr_i[11:0] + ((arlen_i+1) << arsize_i) - 1 in 13 bits, applied to INCR bursts only.
  - If end[12] is set, the burst crosses a 4 KiB boundary. The request is still handshaken (ready_o unchanged) but not written to the FIFO, and req_err_o pulses high for one cycle; the pulse is registered.
- Undefined: no check is made, every accepted request is enqueued, and req_err_o is tied to 0.

Decomposition:
- Package imem_axi_pkg holds:
  - typedef ar_req_t, a struct of addr, len, size and burst;
  - burst encodings BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;
  - constant AXI_4K_BOUNDARY = 4096.
- One sub-module, imem_ar_fifo: a generic synchronous FIFO of ar_req_t, parametrised by DEPTH, exposing push, pop, head, full, empty and level.
- The top level contains the issue gate, the outstanding counter, the ID counter and the optional 4 KiB check.

Test Plan:
- Single request: after reset, push addr=0x1000, len=7, size=3, INCR.
  - Required: arvalid_o is high next cycle with identical payload and arid=0.
  - With arready_i=1, arvalid_o drops and outst_o=1.
- Fill the FIFO, DEPTH=4, arready_i=0: push 5 requests.
  - Required: ready_o=0 after the 4th push, level_o=4, and the 5th request is not accepted.
  - Then one AR handshake: ready_o=1 one cycle later.
- Outstanding limit, MAX_OUTST=2, arready_i=1: queue 3 requests.
  - Required: two bursts issue with arid 0 and 1; arvalid_o stays low while outst_o=2.
  - One R-last handshake: the third burst issues with arid=2.
- AR handshake and R-last in the same cycle at outst=1: outst_o stays 1.
- ID wrap, ID_W=2: issue 5 bursts; required arid sequence is 0, 1, 2, 3, 0.
- Asynchronous reset while arvalid_o=1 and level_o=3: all outputs go to 0 immediately, then ready_o=1 once reset releases.
- With IMEM_AR_4K_CHECK_EN defined:
  - Push addr=0x0FC0, len=7, size=3 (end 0x0FFF): enqueued, req_err_o=0.
  - Push addr=0x0FC8 with the same len and size: req_err_o pulses, level_o does not change.
